// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared state encoding, funct3 codes and byte-mask helpers for
//               the LSU memory sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] C_F3_LB  = 3'b000;
    localparam logic [2:0] C_F3_LH  = 3'b001;
    localparam logic [2:0] C_F3_LW  = 3'b010;
    localparam logic [2:0] C_F3_LBU = 3'b100;
    localparam logic [2:0] C_F3_LHU = 3'b101;
    localparam logic [2:0] C_F3_SB  = 3'b000;
    localparam logic [2:0] C_F3_SH  = 3'b001;
    localparam logic [2:0] C_F3_SW  = 3'b010;

    localparam logic [3:0] C_MASK_B = 4'b0001;
    localparam logic [3:0] C_MASK_H = 4'b0011;
    localparam logic [3:0] C_MASK_W = 4'b1111;

    // Bit n of the result enables byte n of the two-word window {beat1, beat0}.
    function automatic logic [7:0] f_byte_mask(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [3:0] w_base;
        case (funct3[1:0])
            2'b00:   w_base = C_MASK_B;
            2'b01:   w_base = C_MASK_H;
            default: w_base = C_MASK_W;
        endcase
        return {4'b0000, w_base} << addr_lo;
    endfunction

    function automatic logic f_legal(input logic [2:0] funct3,
                                     input logic       is_store);
        logic w_ok;
        if (is_store)
            w_ok = (funct3 == C_F3_SB) || (funct3 == C_F3_SH) || (funct3 == C_F3_SW);
        else
            w_ok = (funct3 == C_F3_LB) || (funct3 == C_F3_LH) || (funct3 == C_F3_LW) ||
                   (funct3 == C_F3_LBU) || (funct3 == C_F3_LHU);
        return w_ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane steering: access mask, shifted store
//               data and extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rdata64,
    output logic [7:0]  o_mask,
    output logic [63:0] o_wdata64,
    output logic [31:0] o_load_data
);

    logic [5:0]  w_shamt;
    logic [31:0] w_rdata;

    assign w_shamt   = {1'b0, i_addr_lo, 3'b000};
    assign o_mask    = f_byte_mask(i_funct3, i_addr_lo);
    assign o_wdata64 = {32'h0000_0000, i_wdata} << w_shamt;
    assign w_rdata   = 32'(i_rdata64 >> w_shamt);

    always_comb begin
        o_load_data = w_rdata;
        case (i_funct3)
            C_F3_LB:  o_load_data = {{24{w_rdata[7]}}, w_rdata[7:0]};
            C_F3_LH:  o_load_data = {{16{w_rdata[15]}}, w_rdata[15:0]};
            C_F3_LBU: o_load_data = {24'h000000, w_rdata[7:0]};
            C_F3_LHU: o_load_data = {16'h0000, w_rdata[15:0]};
            default:  o_load_data = w_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_sequencer.sv
// ============================================================================
// Module      : lsu_mem_sequencer
// Description : Sequences one load/store request into one or two word-aligned
//               memory beats and returns a single-cycle response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned SPLIT_EN = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_beat0_rdata;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic [7:0]  w_req_mask;
    logic        w_req_bad;
    logic [7:0]  w_mask;
    logic        w_misaligned;
    logic [63:0] w_wdata64;
    logic [63:0] w_rdata64;
    logic [31:0] w_load_data;
    logic [31:0] w_base_addr;

    // Request legality is judged on the live inputs so an error skips the beats.
    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_req_mask  = f_byte_mask(req_instr[14:12], req_addr[1:0]);
    assign w_req_bad   = !f_legal(req_instr[14:12], req_instr[5]) ||
                         ((|w_req_mask[7:4]) && (SPLIT_EN == 0));

    assign w_misaligned = |w_mask[7:4];
    assign w_base_addr  = {r_addr[31:2], 2'b00};
    assign w_rdata64    = (r_state == ST_BEAT1) ? {mem_rdata, r_beat0_rdata}
                                                : {32'h0000_0000, mem_rdata};

    lsu_lane_align u_align (
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_rdata64   (w_rdata64),
        .o_mask      (w_mask),
        .o_wdata64   (w_wdata64),
        .o_load_data (w_load_data)
    );

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_we     = 4'h0;
        mem_wdata  = 32'h0000_0000;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept)
                    w_next = w_req_bad ? ST_RESP : ST_BEAT0;
            end
            ST_BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = w_base_addr;
                mem_we    = r_store ? w_mask[3:0] : 4'h0;
                mem_wdata = w_wdata64[31:0];
                if (mem_ack)
                    w_next = w_misaligned ? ST_BEAT1 : ST_RESP;
            end
            ST_BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = w_base_addr + 32'd4;
                mem_we    = r_store ? w_mask[7:4] : 4'h0;
                mem_wdata = w_wdata64[63:32];
                if (mem_ack)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_funct3      <= 3'b000;
            r_store       <= 1'b0;
            r_addr        <= 32'h0000_0000;
            r_wdata       <= 32'h0000_0000;
            r_beat0_rdata <= 32'h0000_0000;
            r_resp_rdata  <= 32'h0000_0000;
            r_resp_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3 <= req_instr[14:12];
                r_store  <= req_instr[5];
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if ((r_state == ST_BEAT0) && mem_ack)
                r_beat0_rdata <= mem_rdata;
            // Response fields are only refreshed on entry to RESP and held otherwise.
            if ((w_next == ST_RESP) && (r_state != ST_RESP)) begin
                r_resp_err   <= (r_state == ST_IDLE);
                r_resp_rdata <= ((r_state == ST_IDLE) || r_store) ? 32'h0000_0000 : w_load_data;
            end
        end
    end

    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_sequencer.sv
// ============================================================================
// Module      : tb_lsu_mem_sequencer
// Description : Directed, table-driven bench for lsu_mem_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid0 = 1'b0;
    logic [31:0] req_instr = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_ack0 = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        req_ready, resp_valid, resp_err, mem_req;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        req_ready0, resp_valid0, resp_err0, mem_req0;
    logic [31:0] resp_rdata0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_we0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_sequencer #(.SPLIT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    lsu_mem_sequencer #(.SPLIT_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_instr(req_instr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0),
        .mem_ack(mem_ack0), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          dly;
        logic        err;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  we0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  we1;
        logic [31:0] wd1;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] f3, logic st, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rd0, logic [31:0] rd1, int dly, logic err, int nb,
                                logic [31:0] a0, logic [3:0] we0, logic [31:0] wd0,
                                logic [31:0] a1, logic [3:0] we1, logic [31:0] wd1,
                                logic [31:0] rdata);
        vec_t v;
        v.f3 = f3; v.st = st; v.addr = addr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
        v.dly = dly; v.err = err; v.nb = nb; v.a0 = a0; v.we0 = we0; v.wd0 = wd0;
        v.a1 = a1; v.we1 = we1; v.wd1 = wd1; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(vec_t v, int idx);
        logic [31:0] ea, ew;
        logic [3:0]  ewe;
        int          t;
        req_instr = {17'h0, v.f3, 6'h0, v.st, 5'h03};
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        if (v.err) begin
            chk($sformatf("v%0d_err_memreq", idx), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_err_valid", idx), 32'(resp_valid), 32'd1);
            chk($sformatf("v%0d_err_flag", idx), 32'(resp_err), 32'd1);
            chk($sformatf("v%0d_err_rdata", idx), resp_rdata, 32'd0);
        end else begin
            for (int b = 0; b < v.nb; b++) begin
                ea  = (b == 0) ? v.a0 : v.a1;
                ewe = (b == 0) ? v.we0 : v.we1;
                ew  = (b == 0) ? v.wd0 : v.wd1;
                t = 0;
                while (!mem_req && t < 8) begin
                    step();
                    t++;
                end
                chk($sformatf("v%0d_b%0d_lat", idx, b), 32'(t), 32'd0);
                for (int d = 0; d <= ((b == 0) ? v.dly : 0); d++) begin
                    if (d > 0) step();
                    chk($sformatf("v%0d_b%0d_req_c%0d", idx, b, d), 32'(mem_req), 32'd1);
                    chk($sformatf("v%0d_b%0d_addr_c%0d", idx, b, d), mem_addr, ea);
                    chk($sformatf("v%0d_b%0d_we_c%0d", idx, b, d), 32'(mem_we), 32'(ewe));
                    chk($sformatf("v%0d_b%0d_wdata_c%0d", idx, b, d), mem_wdata, ew);
                    chk($sformatf("v%0d_b%0d_novalid_c%0d", idx, b, d), 32'(resp_valid), 32'd0);
                end
                mem_ack   = 1'b1;
                mem_rdata = (b == 0) ? v.rd0 : v.rd1;
                step();
                mem_ack   = 1'b0;
            end
            chk($sformatf("v%0d_resp_valid", idx), 32'(resp_valid), 32'd1);
            chk($sformatf("v%0d_resp_err", idx), 32'(resp_err), 32'd0);
            chk($sformatf("v%0d_resp_rdata", idx), resp_rdata, v.rdata);
            chk($sformatf("v%0d_resp_memreq", idx), 32'(mem_req), 32'd0);
        end
        step();
        chk($sformatf("v%0d_pulse_end", idx), 32'(resp_valid), 32'd0);
        chk($sformatf("v%0d_hold_rdata", idx), resp_rdata, v.err ? 32'd0 : v.rdata);
        chk($sformatf("v%0d_hold_err", idx), 32'(resp_err), 32'(v.err));
        chk($sformatf("v%0d_ready_back", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        //                f3    st    addr          wdata         rd0           rd1          dly err nb  a0            we0   wd0           a1            we1   wd1           rdata
        vecs.push_back(mk(3'd0, 1'b1, 32'h0000_1002, 32'h0000_00AB, 32'h0,        32'h0,        0, 0, 1, 32'h0000_1000, 4'h4, 32'h00AB_0000, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(3'd2, 1'b1, 32'h0000_2003, 32'h1122_3344, 32'h0,        32'h0,        5, 0, 2, 32'h0000_2000, 4'h8, 32'h4400_0000, 32'h0000_2004, 4'h7, 32'h0011_2233, 32'h0));
        vecs.push_back(mk(3'd1, 1'b0, 32'h0000_3003, 32'h0,        32'h80FF_FFFF, 32'h0000_0012, 0, 0, 2, 32'h0000_3000, 4'h0, 32'h0,        32'h0000_3004, 4'h0, 32'h0,        32'h0000_1280));
        vecs.push_back(mk(3'd5, 1'b0, 32'h0000_3003, 32'h0,        32'h12FF_FFFF, 32'h0000_0080, 0, 0, 2, 32'h0000_3000, 4'h0, 32'h0,        32'h0000_3004, 4'h0, 32'h0,        32'h0000_8012));
        vecs.push_back(mk(3'd1, 1'b0, 32'h0000_3003, 32'h0,        32'h12FF_FFFF, 32'h0000_0080, 0, 0, 2, 32'h0000_3000, 4'h0, 32'h0,        32'h0000_3004, 4'h0, 32'h0,        32'hFFFF_8012));
        vecs.push_back(mk(3'd0, 1'b0, 32'h0000_5001, 32'h0,        32'h0000_F500, 32'h0,        2, 0, 1, 32'h0000_5000, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_FFF5));
        vecs.push_back(mk(3'd4, 1'b0, 32'h0000_5001, 32'h0,        32'h0000_F500, 32'h0,        0, 0, 1, 32'h0000_5000, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_00F5));
        vecs.push_back(mk(3'd2, 1'b0, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF, 32'h0,        0, 0, 1, 32'h0000_6000, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hDEAD_BEEF));
        vecs.push_back(mk(3'd1, 1'b1, 32'h0000_7002, 32'hCAFE_BABE, 32'h0,        32'h0,        0, 0, 1, 32'h0000_7000, 4'hC, 32'hBABE_0000, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(3'd3, 1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0,        32'h0,        0, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(3'd2, 1'b0, 32'h0000_4001, 32'h0,        32'h4433_2211, 32'h8877_6655, 0, 0, 2, 32'h0000_4000, 4'h0, 32'h0,        32'h0000_4004, 4'h0, 32'h0,        32'h5544_3322));
        vecs.push_back(mk(3'd6, 1'b0, 32'h0000_1000, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(3'd2, 1'b1, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0,        32'h0,        1, 0, 2, 32'hFFFF_FFFC, 4'hC, 32'hC3D4_0000, 32'h0000_0000, 4'h3, 32'h0000_A1B2, 32'h0));
        vecs.push_back(mk(3'd5, 1'b0, 32'h0000_8001, 32'h0,        32'h00AB_CD00, 32'h0,        0, 0, 1, 32'h0000_8000, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_ABCD));
        vecs.push_back(mk(3'd4, 1'b1, 32'h0000_1000, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0));

        // Reset values while held in reset.
        #12;
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Stray mem_ack while idle must do nothing.
        mem_ack = 1'b1;
        step();
        step();
        chk("idle_ack_valid", 32'(resp_valid), 32'd0);
        chk("idle_ack_memreq", 32'(mem_req), 32'd0);
        chk("idle_ack_ready", 32'(req_ready), 32'd1);
        mem_ack = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run(vecs[i], i);

        // SPLIT_EN=0: misaligned LW becomes an error with no memory beat.
        req_instr  = {17'h0, 3'd2, 6'h0, 1'b0, 5'h03};
        req_addr   = 32'h0000_4001;
        req_wdata  = 32'h0;
        req_valid0 = 1'b1;
        chk("ns_ready", 32'(req_ready0), 32'd1);
        step();
        req_valid0 = 1'b0;
        chk("ns_memreq", 32'(mem_req0), 32'd0);
        chk("ns_valid", 32'(resp_valid0), 32'd1);
        chk("ns_err", 32'(resp_err0), 32'd1);
        step();
        chk("ns_pulse_end", 32'(resp_valid0), 32'd0);
        chk("ns_memreq2", 32'(mem_req0), 32'd0);

        // SPLIT_EN=0: aligned LW still completes normally.
        req_addr   = 32'h0000_4000;
        req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        chk("ns_al_memreq", 32'(mem_req0), 32'd1);
        chk("ns_al_addr", mem_addr0, 32'h0000_4000);
        mem_ack0  = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack0  = 1'b0;
        chk("ns_al_valid", 32'(resp_valid0), 32'd1);
        chk("ns_al_err", 32'(resp_err0), 32'd0);
        chk("ns_al_rdata", resp_rdata0, 32'h0BAD_F00D);
        step();

        // Reset while in BEAT1 abandons the access; a held mem_ack is ignored afterwards.
        req_instr = {17'h0, 3'd2, 6'h0, 1'b1, 5'h03};
        req_addr  = 32'h0000_2003;
        req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        step();
        chk("rb_beat1_req", 32'(mem_req), 32'd1);
        chk("rb_beat1_addr", mem_addr, 32'h0000_2004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rb_async_memreq", 32'(mem_req), 32'd0);
        chk("rb_async_addr", mem_addr, 32'd0);
        chk("rb_async_valid", 32'(resp_valid), 32'd0);
        chk("rb_async_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rb_post_valid", 32'(resp_valid), 32'd0);
        chk("rb_post_memreq", 32'(mem_req), 32'd0);
        chk("rb_post_ready", 32'(req_ready), 32'd1);
        step();
        chk("rb_post_valid2", 32'(resp_valid), 32'd0);
        mem_ack = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
